// File: rtl/zero_pattern_gen.sv
// Zero-pattern generator: turns a zero count N into a WIDTH-bit thermometer word
// with N zeros in the LSBs, streamed LSB first and then presented in parallel.
module zero_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    zcount,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic [WIDTH-1:0] word_out,
  output logic             done,
  output logic             err
);

  localparam int            IW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic [CW-1:0]    n_q;
  logic [CW-1:0]    n_d;
  logic             sat_d;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] word_q;
  logic             sout_q;
  logic             sout_valid_q;
  logic             sout_last_q;
  logic             done_q;
  logic             err_q;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sat_d = (zcount > WIDTH_C);
    n_d   = sat_d ? WIDTH_C : zcount;
    idx_d = idx_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the assembly register is reset as well; it is small and keeps X out of word_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      asm_q        <= '0;
      word_q       <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            n_q          <= n_d;
            err_q        <= sat_d;
            idx_q        <= '0;
            // Bit 0 is a zero unless no zeros were requested.
            sout_q       <= (n_d == '0);
            sout_valid_q <= 1'b1;
            sout_last_q  <= (LAST_IDX == '0);
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          asm_q[idx_q] <= sout_q;
          if (sout_last_q) begin
            // The final bit is still in flight, so splice it in directly.
            word_q       <= {sout_q, asm_q[WIDTH-2:0]};
            done_q       <= 1'b1;
            idx_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
            state_q      <= IDLE;
          end else begin
            idx_q       <= idx_d;
            sout_q      <= (CW'(idx_d) >= n_q);
            sout_last_q <= (idx_d == LAST_IDX);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign word_out   = word_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
